// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared constants and types for the UART configuration bank.
//   - function codes of received command frames
//   - response header, status codes and response lengths
//   - bank FSM state type and a saturating counter helper
package uart_cfg_pkg;

  localparam logic [7:0] FN_WR_SHADOW = 8'h01;
  localparam logic [7:0] FN_SET_EN    = 8'h02;
  localparam logic [7:0] FN_COMMIT    = 8'h03;
  localparam logic [7:0] FN_READBACK  = 8'h04;

  localparam logic [7:0] RESP_HDR  = 8'hA5;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BAD_CH = 8'h01;
  localparam logic [7:0] ST_BAD_FN = 8'h02;

  localparam logic [3:0]  RESP_LEN_ACK = 4'd3;
  localparam logic [3:0]  RESP_LEN_RB  = 4'd11;
  localparam int unsigned RESP_MAX     = 11;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } bank_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cfg_bank_if.sv
// uart_cfg_bank_if: frame-in / response-out bundle of the configuration bank.
//   func_reg  : function code of the received frame
//   rev_bus   : payload d1..d10, d1 in [79:72], d10 in [7:0]
//   pack_done : one-cycle valid strobe for func_reg/rev_bus
//   tx_data   : response byte, tx_valid : byte valid, tx_ready : byte accepted
// master = frame receiver + UART transmitter side, slave = the bank.
interface uart_cfg_bank_if;
  logic [7:0]  func_reg;
  logic [79:0] rev_bus;
  logic        pack_done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output func_reg, rev_bus, pack_done, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  func_reg, rev_bus, pack_done, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/uart_resp_ser.sv
// uart_resp_ser: parallel-load response buffer streamed out one byte at a time.
//   clk_50M, rst : clock and synchronous active-high reset
//   i_load       : load i_bytes/i_len and start streaming from byte 0
//   i_len        : number of valid bytes (1..RESP_MAX)
//   i_bytes      : byte 0 in the top byte lane, byte RESP_MAX-1 in [7:0]
//   i_ready      : downstream accepts the current byte
//   o_data       : current byte, o_valid : byte valid
//   o_last       : current byte is the final one of the response
module uart_resp_ser
  import uart_cfg_pkg::*;
(
  input  logic                  clk_50M,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [3:0]            i_len,
  input  logic [8*RESP_MAX-1:0] i_bytes,
  input  logic                  i_ready,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  output logic                  o_last
);

  logic [7:0] r_buf [RESP_MAX];
  logic [3:0] r_len;
  logic [3:0] r_idx;
  logic       r_valid;
  logic       w_last;

  assign w_last = r_valid && (r_idx == r_len - 4'd1);

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      for (int k = 0; k < RESP_MAX; k++) r_buf[k] <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      for (int k = 0; k < RESP_MAX; k++) r_buf[k] <= i_bytes[8*(RESP_MAX-1-k) +: 8];
      r_len   <= i_len;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      if (w_last) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  // Data comes straight from registers, so it cannot move during a stall.
  assign o_data  = r_buf[r_idx];
  assign o_valid = r_valid;
  assign o_last  = w_last;

endmodule

// File: rtl/uart_cfg_bank.sv
// uart_cfg_bank: decodes UART command frames into per-channel shadow registers,
// commits shadows to active registers under a channel mask, and answers every
// frame with an ack or readback byte stream.
//   clk_50M, rst  : clock and synchronous active-high reset
//   frm           : frame input and response output bundle (slave side)
//   ch_en         : per-channel enable
//   duty_bus      : active duty, channel i in [8i+7:8i]
//   dessert_bus   : active pulse_dessert, 16 bits per channel
//   num_bus       : active pulse_num, 8 bits per channel
//   pat_bus       : active pattern, PAT_WIDTH bits per channel
//   cfg_update    : one-cycle pulse per committed channel
//   busy          : frame executing or response pending
//   err_cnt       : rejected frames, saturating
//   ovf_cnt       : frames dropped while busy, saturating
module uart_cfg_bank
  import uart_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PAT_WIDTH = 32,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk_50M,
  input  logic                          rst,
  uart_cfg_bank_if.slave                frm,
  output logic [NUM_CH-1:0]             ch_en,
  output logic [8*NUM_CH-1:0]           duty_bus,
  output logic [16*NUM_CH-1:0]          dessert_bus,
  output logic [8*NUM_CH-1:0]           num_bus,
  output logic [PAT_WIDTH*NUM_CH-1:0]   pat_bus,
  output logic [NUM_CH-1:0]             cfg_update,
  output logic                          busy,
  output logic [7:0]                    err_cnt,
  output logic [7:0]                    ovf_cnt
);

  bank_state_e          r_state;
  logic [7:0]           r_func;
  logic [79:0]          r_bus;
  logic                 r_busy;
  logic [7:0]           r_err;
  logic [7:0]           r_ovf;
  logic [NUM_CH-1:0]    r_ch_en;
  logic [NUM_CH-1:0]    r_upd;

  logic [7:0]           r_sh_duty [NUM_CH];
  logic [15:0]          r_sh_des  [NUM_CH];
  logic [7:0]           r_sh_num  [NUM_CH];
  logic [PAT_WIDTH-1:0] r_sh_pat  [NUM_CH];
  logic [7:0]           r_ac_duty [NUM_CH];
  logic [15:0]          r_ac_des  [NUM_CH];
  logic [7:0]           r_ac_num  [NUM_CH];
  logic [PAT_WIDTH-1:0] r_ac_pat  [NUM_CH];

  logic [7:0]           w_d [1:10];
  logic [CH_W-1:0]      w_ch;
  logic                 w_ch_ok;
  logic [31:0]          w_pat32;
  logic [7:0]           w_status;
  logic                 w_is_rb;
  logic [3:0]           w_len;
  logic [8*RESP_MAX-1:0] w_resp;
  logic [7:0]           w_rb_duty;
  logic [15:0]          w_rb_des;
  logic [7:0]           w_rb_num;
  logic [31:0]          w_rb_pat;
  logic                 w_load;
  logic                 w_last;

  // Payload bytes of the latched frame, d1 in the top lane.
  always_comb begin
    for (int k = 1; k <= 10; k++) w_d[k] = r_bus[8*(10-k) +: 8];
  end

  assign w_ch    = w_d[1][CH_W-1:0];
  assign w_ch_ok = 32'(w_d[1]) < NUM_CH;
  assign w_pat32 = {w_d[7], w_d[8], w_d[9], w_d[10]};

  // Active values of the addressed channel, sampled while in EXEC.
  always_comb begin
    w_rb_duty = '0;
    w_rb_des  = '0;
    w_rb_num  = '0;
    w_rb_pat  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == CH_W'(i)) begin
        w_rb_duty = r_ac_duty[i];
        w_rb_des  = r_ac_des[i];
        w_rb_num  = r_ac_num[i];
        w_rb_pat  = 32'(r_ac_pat[i]);
      end
    end
  end

  // Frame decode and response image.
  always_comb begin
    w_status = ST_OK;
    w_is_rb  = 1'b0;
    case (r_func)
      FN_WR_SHADOW, FN_SET_EN: if (!w_ch_ok) w_status = ST_BAD_CH;
      FN_COMMIT:               w_status = ST_OK;
      FN_READBACK: begin
        if (!w_ch_ok) w_status = ST_BAD_CH;
        else          w_is_rb  = 1'b1;
      end
      default:                 w_status = ST_BAD_FN;
    endcase

    w_resp         = '0;
    w_resp[87:80]  = RESP_HDR;
    w_resp[79:72]  = r_func;
    if (w_is_rb) begin
      w_resp[71:0] = {w_d[1], w_rb_duty, w_rb_des, w_rb_num, w_rb_pat};
      w_len        = RESP_LEN_RB;
    end else begin
      w_resp[71:64] = w_status;
      w_len         = RESP_LEN_ACK;
    end
  end

  assign w_load = (r_state == StExec);

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state <= StIdle;
      r_func  <= '0;
      r_bus   <= '0;
      r_busy  <= 1'b0;
      r_err   <= '0;
      r_ovf   <= '0;
      r_ch_en <= '0;
      r_upd   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_sh_duty[i] <= '0;
        r_sh_des[i]  <= '0;
        r_sh_num[i]  <= '0;
        r_sh_pat[i]  <= '0;
        r_ac_duty[i] <= '0;
        r_ac_des[i]  <= '0;
        r_ac_num[i]  <= '0;
        r_ac_pat[i]  <= '0;
      end
    end else begin
      r_upd <= '0;
      unique case (r_state)
        StIdle: begin
          if (frm.pack_done) begin
            r_func  <= frm.func_reg;
            r_bus   <= frm.rev_bus;
            r_busy  <= 1'b1;
            r_state <= StExec;
          end
        end
        StExec: begin
          if (w_status != ST_OK) begin
            r_err <= sat_inc(r_err);
          end else begin
            case (r_func)
              FN_WR_SHADOW: begin
                for (int i = 0; i < NUM_CH; i++) begin
                  if (w_ch == CH_W'(i)) begin
                    r_sh_duty[i] <= w_d[3];
                    r_sh_des[i]  <= {w_d[4], w_d[5]};
                    r_sh_num[i]  <= w_d[6];
                    r_sh_pat[i]  <= w_pat32[PAT_WIDTH-1:0];
                  end
                end
              end
              FN_SET_EN: begin
                for (int i = 0; i < NUM_CH; i++) begin
                  if (w_ch == CH_W'(i)) r_ch_en[i] <= w_d[2][0];
                end
              end
              FN_COMMIT: begin
                // d1 is a channel mask here; bits at or above NUM_CH never match.
                for (int i = 0; i < NUM_CH; i++) begin
                  if (w_d[1][i]) begin
                    r_ac_duty[i] <= r_sh_duty[i];
                    r_ac_des[i]  <= r_sh_des[i];
                    r_ac_num[i]  <= r_sh_num[i];
                    r_ac_pat[i]  <= r_sh_pat[i];
                    r_upd[i]     <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
          r_state <= StResp;
        end
        StResp: begin
          if (w_last && frm.tx_ready) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
      // Any strobe outside IDLE is lost, including the cycle of the final accept.
      if (frm.pack_done && (r_state != StIdle)) r_ovf <= sat_inc(r_ovf);
    end
  end

  uart_resp_ser u_resp_ser (
    .clk_50M (clk_50M),
    .rst     (rst),
    .i_load  (w_load),
    .i_len   (w_len),
    .i_bytes (w_resp),
    .i_ready (frm.tx_ready),
    .o_data  (frm.tx_data),
    .o_valid (frm.tx_valid),
    .o_last  (w_last)
  );

  always_comb begin
    duty_bus    = '0;
    dessert_bus = '0;
    num_bus     = '0;
    pat_bus     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      duty_bus[8*i +: 8]                  = r_ac_duty[i];
      dessert_bus[16*i +: 16]             = r_ac_des[i];
      num_bus[8*i +: 8]                   = r_ac_num[i];
      pat_bus[PAT_WIDTH*i +: PAT_WIDTH]   = r_ac_pat[i];
    end
  end

  assign ch_en      = r_ch_en;
  assign cfg_update = r_upd;
  assign busy       = r_busy;
  assign err_cnt    = r_err;
  assign ovf_cnt    = r_ovf;

endmodule
